ntt_sdf_output_reorder: RTL

NTT_SDF_OUTPUT_REORDER -- requirements
Module: ntt_sdf_output_reorder

---
 rtl/ntt_sdf_output_reorder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ntt_sdf_output_reorder.sv
// Bit-reversed to natural-order reorder buffer behind the last SDF NTT stage: two ping-pong banks with a
// prefetching ready/valid reader. Define NTT_REORDER_BYPASS_EN to add the per-frame linear-write bypass input.
module ntt_sdf_output_reorder #(
   parameter int LOGQ = 32,
   parameter int LOGN = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [LOGQ-1:0] in_data,
`ifdef NTT_REORDER_BYPASS_EN
   input  logic            bypass,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGQ-1:0] out_data,
   output logic            out_last,
   output logic            overflow,
   output logic            busy
);
   localparam int N = 1 << LOGN;

   typedef enum logic [1:0] {IDLE = 2'd0, PREFETCH = 2'd1, STREAM = 2'd2} rd_state_e;

   function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] a);
      logic [LOGN-1:0] r;
      for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
      return r;
   endfunction

   logic [LOGQ-1:0] mem_r [0:2*N-1];
   logic [LOGQ-1:0] out_data_r;
   logic [LOGN-1:0] wcnt_r, wcnt_s, rcnt_r, rcnt_s, rd_ptr_s;
   logic            wsel_r, rsel_r;
   logic [1:0]      full_r, full_s, full_set_s, full_clr_s;
   rd_state_e       state_r, state_s;
   logic            out_valid_r, out_last_r, overflow_r, busy_r;
   logic            wr_en_s, wr_wrap_s, drop_s, xfer_s, rd_last_s, rd_en_s, lin_s;
   logic [LOGN:0]   wr_addr_s;

   // A sample is only accepted into a bank that has not been handed to the reader.
   assign wr_en_s   = in_valid & ~full_r[wsel_r];
   assign drop_s    = in_valid & full_r[wsel_r];
   assign wr_wrap_s = wr_en_s & (&wcnt_r);
   assign wcnt_s    = wr_en_s ? (wcnt_r + LOGN'(1)) : wcnt_r;
   assign wr_addr_s = {wsel_r, (lin_s ? wcnt_r : bit_rev(wcnt_r))};

   assign xfer_s    = out_valid_r & out_ready;
   assign rd_last_s = xfer_s & out_last_r;

   // Writer and reader never own the same bank, so set and clear never collide on one flag.
   assign full_set_s = wr_wrap_s ? (wsel_r ? 2'b10 : 2'b01) : 2'b00;
   assign full_clr_s = rd_last_s ? (rsel_r ? 2'b10 : 2'b01) : 2'b00;
   assign full_s     = (full_r & ~full_clr_s) | full_set_s;

`ifdef NTT_REORDER_BYPASS_EN
   logic bypass_r;
   // The first word of a frame uses the live bypass input; the rest of the frame uses its captured copy.
   assign lin_s = (|wcnt_r) ? bypass_r : bypass;

   // Capture the bypass mode on the first accepted word of each frame.
   always_ff @(posedge clk) begin
      if (rst) bypass_r <= 1'b0;
      else if (wr_en_s && !(|wcnt_r)) bypass_r <= bypass;
   end
`else
   assign lin_s = 1'b0;
`endif

   // Reader next-state: prefetch word 0, then read one word ahead on every transfer.
   always_comb begin
      state_s  = state_r;
      rcnt_s   = rcnt_r;
      rd_en_s  = 1'b0;
      rd_ptr_s = rcnt_r;
      case (state_r)
         IDLE: begin
            if (full_r[rsel_r]) state_s = PREFETCH;
            else state_s = IDLE;
         end
         PREFETCH: begin
            rd_en_s  = 1'b1;
            rd_ptr_s = {LOGN{1'b0}};
            rcnt_s   = {LOGN{1'b0}};
            state_s  = STREAM;
         end
         STREAM: begin
            if (rd_last_s) begin
               rcnt_s  = {LOGN{1'b0}};
               state_s = full_r[~rsel_r] ? PREFETCH : IDLE;
            end else if (xfer_s) begin
               rcnt_s   = rcnt_r + LOGN'(1);
               rd_ptr_s = rcnt_r + LOGN'(1);
               rd_en_s  = 1'b1;
            end else begin
               state_s = STREAM;
            end
         end
         default: begin
            state_s = IDLE;
            rcnt_s  = {LOGN{1'b0}};
         end
      endcase
   end

   // Control state, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_r      <= {LOGN{1'b0}};
         rcnt_r      <= {LOGN{1'b0}};
         wsel_r      <= 1'b0;
         rsel_r      <= 1'b0;
         full_r      <= 2'b00;
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         overflow_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         wcnt_r      <= wcnt_s;
         rcnt_r      <= rcnt_s;
         wsel_r      <= wsel_r ^ wr_wrap_s;
         rsel_r      <= rsel_r ^ rd_last_s;
         full_r      <= full_s;
         state_r     <= state_s;
         out_valid_r <= (state_s == STREAM);
         out_last_r  <= (state_s == STREAM) & (&rcnt_s);
         overflow_r  <= overflow_r | drop_s;
         busy_r      <= (|full_s) | (|wcnt_s);
      end
   end

   // Bank storage: one write port for the writer, one synchronous read port for the reader.
   always_ff @(posedge clk) begin
      if (wr_en_s && !rst) mem_r[wr_addr_s] <= in_data;
      if (rd_en_s) out_data_r <= mem_r[{rsel_r, rd_ptr_s}];
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign overflow  = overflow_r;
   assign busy      = busy_r;
endmodule
